// File: rtl/ahb_master_mux.sv
// AHB 16-master address/data multiplexer with data-phase tracking
// and a sticky ownership/lock protocol-violation monitor.
module ahb_master_mux (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic [3:0]   HMASTER,
    input  logic         HMASTLOCK,
    input  logic         HREADY,
    input  logic [511:0] HADDRx,
    input  logic [31:0]  HTRANSx,
    input  logic [15:0]  HWRITEx,
    input  logic [47:0]  HSIZEx,
    input  logic [47:0]  HBURSTx,
    input  logic [511:0] HWDATAx,
    output logic [31:0]  HADDR,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [2:0]   HSIZE,
    output logic [2:0]   HBURST,
    output logic [31:0]  HWDATA,
    output logic [3:0]   HMASTER_DP,
    output logic         HMASTLOCK_DP,
    output logic         DP_ACTIVE,
    output logic         SEQ_ERR,
    output logic [7:0]   SEQ_ERR_CNT
);

    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    logic [3:0] last_owner;
    logic [8:0] a_base;
    logic [8:0] d_base;
    logic [4:0] t_base;
    logic [5:0] c_base;
    logic       own_change;
    logic       bad_first;
    logic       lock_break;
    logic       viol;

    assign a_base = {HMASTER, 5'b0};
    assign d_base = {HMASTER_DP, 5'b0};
    assign t_base = {HMASTER, 1'b0};
    assign c_base = {2'b0, HMASTER} + {1'b0, HMASTER, 1'b0};

    assign HADDR  = HADDRx[a_base +: 32];
    assign HTRANS = HTRANSx[t_base +: 2];
    assign HWRITE = HWRITEx[HMASTER];
    assign HSIZE  = HSIZEx[c_base +: 3];
    assign HBURST = HBURSTx[c_base +: 3];
    assign HWDATA = HWDATAx[d_base +: 32];

    assign own_change = (HMASTER != last_owner);
    assign bad_first  = own_change &&
                        (HTRANS == TR_SEQ || HTRANS == TR_BUSY);
    assign lock_break = own_change && HMASTLOCK_DP && DP_ACTIVE;
    assign viol       = HREADY && (bad_first || lock_break);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HMASTER_DP   <= 4'h0;
            HMASTLOCK_DP <= 1'b0;
            DP_ACTIVE    <= 1'b0;
            last_owner   <= 4'h0;
        end else if (HREADY) begin
            HMASTER_DP   <= HMASTER;
            HMASTLOCK_DP <= HMASTLOCK;
            DP_ACTIVE    <= HTRANS[1];
            last_owner   <= HMASTER;
        end
    end

    // Error counter saturates so a long fault storm stays visible.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            SEQ_ERR     <= 1'b0;
            SEQ_ERR_CNT <= 8'h00;
        end else if (viol) begin
            SEQ_ERR <= 1'b1;
            if (SEQ_ERR_CNT != 8'hFF)
                SEQ_ERR_CNT <= SEQ_ERR_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_ahb_master_mux.sv
// Self-checking bench for ahb_master_mux: mux table, directed
// scenarios and randomized traffic against a transfer-level model.
module tb_ahb_master_mux;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [3:0]   HMASTER;
    logic         HMASTLOCK;
    logic         HREADY;
    logic [511:0] HADDRx;
    logic [31:0]  HTRANSx;
    logic [15:0]  HWRITEx;
    logic [47:0]  HSIZEx;
    logic [47:0]  HBURSTx;
    logic [511:0] HWDATAx;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic [31:0]  HWDATA;
    logic [3:0]   HMASTER_DP;
    logic         HMASTLOCK_DP;
    logic         DP_ACTIVE;
    logic         SEQ_ERR;
    logic [7:0]   SEQ_ERR_CNT;

    logic [31:0] addr  [16];
    logic [31:0] wdata [16];
    logic [1:0]  trans [16];
    logic        wr    [16];
    logic [2:0]  size  [16];
    logic [2:0]  burst [16];

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 16; g++) begin : g_pack
        assign HADDRx[32*g +: 32]  = addr[g];
        assign HWDATAx[32*g +: 32] = wdata[g];
        assign HTRANSx[2*g +: 2]   = trans[g];
        assign HWRITEx[g]          = wr[g];
        assign HSIZEx[3*g +: 3]    = size[g];
        assign HBURSTx[3*g +: 3]   = burst[g];
    end

    ahb_master_mux dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HMASTER     (HMASTER),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .HADDRx      (HADDRx),
        .HTRANSx     (HTRANSx),
        .HWRITEx     (HWRITEx),
        .HSIZEx      (HSIZEx),
        .HBURSTx     (HBURSTx),
        .HWDATAx     (HWDATAx),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HWDATA      (HWDATA),
        .HMASTER_DP  (HMASTER_DP),
        .HMASTLOCK_DP(HMASTLOCK_DP),
        .DP_ACTIVE   (DP_ACTIVE),
        .SEQ_ERR     (SEQ_ERR),
        .SEQ_ERR_CNT (SEQ_ERR_CNT)
    );

    int compared = 0;
    int failed   = 0;

    // Transfer-level model: who owns the data phase, what was granted.
    int m_dp, m_last, m_cnt;
    bit m_lock, m_act, m_err;

    typedef struct {
        logic [3:0]  m;
        logic [31:0] a;
        logic [1:0]  t;
        logic        w;
        logic [2:0]  s;
        logic [2:0]  b;
    } mux_vec_t;

    mux_vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_dp = 0; m_last = 0; m_cnt = 0;
        m_lock = 0; m_act = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit chg, v;
        logic [1:0] t;
        if (!HREADY) return;
        t   = trans[HMASTER];
        chg = (int'(HMASTER) != m_last);
        v   = (chg && (t == 2'b01 || t == 2'b11)) ||
              (chg && m_lock && m_act);
        if (v) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
        end
        m_dp   = HMASTER;
        m_last = HMASTER;
        m_lock = HMASTLOCK;
        m_act  = (t == 2'b10 || t == 2'b11);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_dp"},   32'(HMASTER_DP),   32'(m_dp));
        chk({tag, "_act"},  32'(DP_ACTIVE),    32'(m_act));
        chk({tag, "_lock"}, 32'(HMASTLOCK_DP), 32'(m_lock));
        chk({tag, "_err"},  32'(SEQ_ERR),      32'(m_err));
        chk({tag, "_cnt"},  32'(SEQ_ERR_CNT),  32'(m_cnt));
        chk({tag, "_wd"},   HWDATA,            wdata[m_dp]);
    endtask

    task automatic check_addr(input string tag);
        chk({tag, "_haddr"},  HADDR,          addr[HMASTER]);
        chk({tag, "_htrans"}, 32'(HTRANS),    32'(trans[HMASTER]));
        chk({tag, "_hwrite"}, 32'(HWRITE),    32'(wr[HMASTER]));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge HCLK);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        model_reset();
        #2;
        chk("rst_dp",  32'(HMASTER_DP),  32'h0);
        chk("rst_act", 32'(DP_ACTIVE),   32'h0);
        chk("rst_err", 32'(SEQ_ERR),     32'h0);
        chk("rst_cnt", 32'(SEQ_ERR_CNT), 32'h0);
        chk("rst_wd",  HWDATA,           wdata[0]);
        HRESETn = 1'b1;
    endtask

    task automatic set_all_idle();
        for (int i = 0; i < 16; i++) trans[i] = 2'b00;
    endtask

    initial begin
        tbl[0] = '{4'd0,  32'hA0A0_0000, 2'd0, 1'b1, 3'd0, 3'd0};
        tbl[1] = '{4'd3,  32'hA0A0_0003, 2'd3, 1'b0, 3'd3, 3'd1};
        tbl[2] = '{4'd7,  32'hA0A0_0007, 2'd3, 1'b0, 3'd7, 3'd3};
        tbl[3] = '{4'd10, 32'hA0A0_000A, 2'd2, 1'b1, 3'd2, 3'd5};
        tbl[4] = '{4'd15, 32'hA0A0_000F, 2'd3, 1'b0, 3'd7, 3'd7};

        for (int i = 0; i < 16; i++) begin
            addr[i]  = 32'hA0A0_0000 + 32'(i);
            wdata[i] = 32'hD0D0_0000 + 32'(i);
            trans[i] = 2'(i);
            wr[i]    = ~1'(i);
            size[i]  = 3'(i);
            burst[i] = 3'(i >> 1);
        end
        HMASTER   = 4'd0;
        HMASTLOCK = 1'b0;
        HREADY    = 1'b0;
        #1;
        do_reset();

        // Address mux table (HREADY low, so no state moves).
        foreach (tbl[k]) begin
            HMASTER = tbl[k].m;
            #1;
            chk("tbl_addr",  HADDR,         tbl[k].a);
            chk("tbl_trans", 32'(HTRANS),   32'(tbl[k].t));
            chk("tbl_write", 32'(HWRITE),   32'(tbl[k].w));
            chk("tbl_size",  32'(HSIZE),    32'(tbl[k].s));
            chk("tbl_burst", 32'(HBURST),   32'(tbl[k].b));
        end
        chk("tbl_dp_hold", 32'(HMASTER_DP), 32'h0);

        // First transfer from master 3, then wait states while 5 asks.
        set_all_idle();
        HMASTER  = 4'd3;
        HREADY   = 1'b1;
        trans[3] = 2'b10;
        addr[3]  = 32'h1000;
        #1;
        chk("s16_haddr", HADDR, 32'h1000);
        tick("s16");
        chk("s16_dp",  32'(HMASTER_DP), 32'd3);
        chk("s16_act", 32'(DP_ACTIVE),  32'd1);
        chk("s16_wd",  HWDATA,          32'hD0D0_0003);

        HREADY   = 1'b0;
        HMASTER  = 4'd5;
        trans[5] = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("s17_haddr", HADDR, addr[5]);
            tick("s17w");
            chk("s17_dp", 32'(HMASTER_DP), 32'd3);
            chk("s17_wd", HWDATA,          32'hD0D0_0003);
        end
        HREADY = 1'b1;
        tick("s17r");
        chk("s17_dp5", 32'(HMASTER_DP), 32'd5);
        chk("s17_err", 32'(SEQ_ERR),    32'd0);

        // Ownership change straight into SEQ.
        HMASTER  = 4'd3;
        trans[3] = 2'b10;
        tick("s18a");
        HMASTER  = 4'd5;
        trans[5] = 2'b11;
        tick("s18b");
        chk("s18_err", 32'(SEQ_ERR),     32'd1);
        chk("s18_cnt", 32'(SEQ_ERR_CNT), 32'd1);
        trans[5] = 2'b00;
        for (int c = 0; c < 10; c++) tick("s18c");
        chk("s18_sticky", 32'(SEQ_ERR),     32'd1);
        chk("s18_cnt10",  32'(SEQ_ERR_CNT), 32'd1);

        // Locked NONSEQ broken by a grant to another master.
        do_reset();
        set_all_idle();
        HMASTER   = 4'd2;
        HMASTLOCK = 1'b1;
        trans[2]  = 2'b10;
        tick("s19a");
        chk("s19_cnt0", 32'(SEQ_ERR_CNT), 32'd0);
        HMASTER   = 4'd4;
        HMASTLOCK = 1'b0;
        trans[4]  = 2'b11;
        tick("s19b");
        chk("s19_cnt1", 32'(SEQ_ERR_CNT), 32'd1);
        trans[4] = 2'b00;
        tick("s19c");
        chk("s19_hold", 32'(SEQ_ERR_CNT), 32'd1);

        // Violation storm to saturation, then async reset mid-cycle.
        for (int i = 0; i < 16; i++) trans[i] = 2'b11;
        for (int c = 0; c < 300; c++) begin
            HMASTER = (c % 2 == 0) ? 4'd1 : 4'd2;
            tick("s20");
        end
        chk("s20_sat", 32'(SEQ_ERR_CNT), 32'hFF);
        tick("s20h");
        chk("s20_hold", 32'(SEQ_ERR_CNT), 32'hFF);
        #3;
        HRESETn = 1'b0;
        model_reset();
        #1;
        chk("s20_clr_cnt", 32'(SEQ_ERR_CNT), 32'h0);
        chk("s20_clr_err", 32'(SEQ_ERR),     32'h0);
        chk("s20_clr_act", 32'(DP_ACTIVE),   32'h0);
        HRESETn = 1'b1;
        HREADY  = 1'b0;
        tick("s15");
        chk("s15_act", 32'(DP_ACTIVE), 32'h0);

        // Legal random arbitration: never an error.
        for (int c = 0; c < 2000; c++) begin
            int nm;
            for (int i = 0; i < 16; i++) begin
                trans[i] = 2'($urandom);
                addr[i]  = $urandom;
                wdata[i] = $urandom;
                wr[i]    = 1'($urandom);
                size[i]  = 3'($urandom);
                burst[i] = 3'($urandom);
            end
            HREADY = ($urandom_range(0, 9) < 7);
            if (m_lock && m_act)
                nm = m_last;
            else if ($urandom_range(0, 1) == 0)
                nm = m_last;
            else
                nm = $urandom_range(0, 15);
            HMASTER   = 4'(nm);
            HMASTLOCK = ($urandom_range(0, 9) < 3);
            if (nm != m_last)
                trans[nm] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
            #1;
            check_addr("leg");
            tick("leg");
            chk("leg_noerr", 32'(SEQ_ERR), 32'd0);
        end

        // Unconstrained random traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 16; i++) begin
                trans[i] = 2'($urandom);
                addr[i]  = $urandom;
                wdata[i] = $urandom;
                wr[i]    = 1'($urandom);
            end
            HREADY    = ($urandom_range(0, 9) < 7);
            HMASTER   = ($urandom_range(0, 3) == 0) ?
                        4'($urandom) : 4'(m_last);
            HMASTLOCK = 1'($urandom);
            #1;
            check_addr("rnd");
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, failed);
        $finish;
    end

endmodule
